// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver.
// Synchronises the raw ps2_clk/ps2_data pins and assembles 11-bit frames:
// start, 8 data bits LSB first, odd parity, stop. E0/F0 prefix bytes are
// folded into the ext/break flags of the following key event.
// Ports:
//   clk, rst_n           system clock, synchronous active-low reset
//   ena                  design enable; low forces idle
//   ps2_clk, ps2_data    raw asynchronous PS/2 pins
//   key_valid            one-cycle strobe, new event on key_code/key_break/key_ext
//   key_code             received scancode byte
//   key_break, key_ext   event was preceded by F0 / E0
//   frame_err            one-cycle strobe on start/parity/stop error or timeout
//   busy                 high while a frame is being received
module ps2_frame_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned CW         = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;
    logic [FRAME_BITS-1:0]  shreg;
    logic [CW-1:0]          bit_cnt;
    logic [TW-1:0]          tcnt;
    logic                   ext_pending;
    logic                   brk_pending;
    logic [7:0]             rx_byte;
    logic                   frame_ok;

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign fall     = clk_prev & ~clk_s;
    assign rx_byte  = shreg[8:1];
    // Start low, stop high, odd parity over data plus parity bit.
    assign frame_ok = ~shreg[0] & shreg[10] & (^shreg[9:1]);

    // Input synchronisers and edge-detect history; idle bus is high.
    // These keep running while ena is low so a stale level never looks like an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    // Frame FSM, prefix tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            tcnt        <= '0;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
            key_valid   <= 1'b0;
            key_code    <= 8'h00;
            key_break   <= 1'b0;
            key_ext     <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (!ena) begin
                state       <= IDLE;
                bit_cnt     <= '0;
                tcnt        <= '0;
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        tcnt <= '0;
                        if (fall) begin
                            shreg[0] <= data_s;
                            bit_cnt  <= CW'(1);
                            busy     <= 1'b1;
                            state    <= SHIFT;
                        end
                    end

                    SHIFT: begin
                        if (fall) begin
                            shreg[bit_cnt] <= data_s;
                            bit_cnt        <= bit_cnt + CW'(1);
                            tcnt           <= '0;
                            if (bit_cnt == CW'(FRAME_BITS - 1)) begin
                                state <= CHECK;
                            end
                        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            // This cycle makes TIMEOUT_CYCLES without a fall: abort.
                            state       <= IDLE;
                            bit_cnt     <= '0;
                            tcnt        <= '0;
                            busy        <= 1'b0;
                            frame_err   <= 1'b1;
                            ext_pending <= 1'b0;
                            brk_pending <= 1'b0;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end

                    CHECK: begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        tcnt    <= '0;
                        busy    <= 1'b0;
                        if (frame_ok) begin
                            if (rx_byte == 8'hE0) begin
                                ext_pending <= 1'b1;
                            end else if (rx_byte == 8'hF0) begin
                                brk_pending <= 1'b1;
                            end else begin
                                key_code    <= rx_byte;
                                key_break   <= brk_pending;
                                key_ext     <= ext_pending;
                                key_valid   <= 1'b1;
                                ext_pending <= 1'b0;
                                brk_pending <= 1'b0;
                            end
                        end else begin
                            frame_err   <= 1'b1;
                            ext_pending <= 1'b0;
                            brk_pending <= 1'b0;
                        end
                        // A fall here is the start bit of the next frame.
                        if (fall) begin
                            shreg[0] <= data_s;
                            bit_cnt  <= CW'(1);
                            busy     <= 1'b1;
                            state    <= SHIFT;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
